conv_result_regfile: RTL and testbench

- Result register file directly downstream of the write-address counter in the CNN single-layer datapath.
- Captures each multiplier result at the 4-bit write address produced by the write-address counter. Tracks which of the 15 slots have been filled.
- Once all slots are filled, drains the results in address order to the next stage over a valid/ready handshake, then re-arms for the next window.

---
 rtl/cnn_pkg.sv | 18 +
 rtl/conv_result_drain_ctrl.sv | 82 ++++++++
 rtl/conv_result_regfile.sv | 139 +++++++++++++
 tb/tb_conv_result_regfile.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg
// Shared definitions for the CNN single-layer datapath result stage:
// default widths/depth of the result register file and the FILL/DRAIN
// state encoding used by its drain controller.
// Optional feature used by conv_result_regfile: CONV_RESULT_ACCUM_EN.
// No ports (package).
package cnn_pkg;

    localparam int CNN_DATA_W = 16;
    localparam int CNN_DEPTH  = 15;
    localparam int CNN_ADDR_W = 4;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_t;

endpackage

// File: rtl/conv_result_drain_ctrl.sv
// conv_result_drain_ctrl
// Owns the FILL/DRAIN state, the read pointer and the drain handshake of
// the result register file.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_FILL  | accepting writes; waiting for every slot to be written
// ST_DRAIN | presenting slot rd_ptr downstream; advancing on each accept
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous reset, active high
//   mask_full  in   this edge's write completes the valid mask
//   fire       in   out_valid && out_ready this cycle
//   draining   out  state is ST_DRAIN
//   rd_ptr     out  current drain slot, 0..DEPTH-1
//   drain_done out  last slot accepted this cycle; mask must clear
module conv_result_drain_ctrl
    import cnn_pkg::*;
#(
    parameter int DEPTH  = CNN_DEPTH,
    parameter int ADDR_W = CNN_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mask_full,
    input  logic              fire,
    output logic              draining,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic              drain_done
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    drain_state_t      state;
    drain_state_t      state_nxt;
    logic [ADDR_W-1:0] rd_ptr_nxt;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state  <= ST_FILL;
            rd_ptr <= '0;
        end else begin
            state  <= state_nxt;
            rd_ptr <= rd_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rd_ptr_nxt = rd_ptr;
        drain_done = 1'b0;
        case (state)
            ST_FILL: begin
                if (mask_full) begin
                    state_nxt  = ST_DRAIN;
                    rd_ptr_nxt = '0;
                end
            end
            ST_DRAIN: begin
                if (fire) begin
                    if (rd_ptr == LAST_PTR) begin
                        // wrap explicitly so rd_ptr never reaches DEPTH
                        state_nxt  = ST_FILL;
                        rd_ptr_nxt = '0;
                        drain_done = 1'b1;
                    end else begin
                        rd_ptr_nxt = rd_ptr + PTR_ONE;
                    end
                end
            end
            default: begin
                state_nxt  = ST_FILL;
                rd_ptr_nxt = '0;
            end
        endcase
    end

    assign draining = (state == ST_DRAIN);

endmodule

// File: rtl/conv_result_regfile.sv
// conv_result_regfile
// Result register file behind the write-address counter. Captures each
// multiplier result at its 4-bit write address, tracks which of the DEPTH
// slots are filled, then drains all slots in address order over a
// valid/ready handshake and re-arms for the next window.
//
// Optional feature macro: CONV_RESULT_ACCUM_EN
//   defined   - a rewrite of an already-filled slot accumulates
//               (mem + WriteData, modulo 2^DATA_W)
//   undefined - a rewrite overwrites; no adder is built
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous reset, active high
//   Start      in   write strobe for WriteReg/WriteData
//   WriteReg   in   write address (ADDR_W)
//   WriteData  in   result to store (DATA_W)
//   out_valid  out  drain data valid
//   out_ready  in   downstream accepts out_data
//   out_data   out  mem[rd_ptr] while draining, else 0
//   out_addr   out  rd_ptr while draining, else 0
//   full       out  every slot written; high for the whole drain
//   overflow   out  sticky: a write was dropped
module conv_result_regfile
    import cnn_pkg::*;
#(
    parameter int DATA_W = CNN_DATA_W,
    parameter int DEPTH  = CNN_DEPTH,
    parameter int ADDR_W = CNN_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Start,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              full,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid_mask;
    logic [DEPTH-1:0]  mask_set;
    logic [DEPTH-1:0]  mask_nxt;
    logic              draining;
    logic              drain_done;
    logic              fire;
    logic              addr_ok;
    logic              wr_en;
    logic              wr_drop;
    logic              mask_full;
    logic [ADDR_W-1:0] rd_ptr;

    assign addr_ok = (WriteReg < DEPTH_A);
    assign wr_en   = Start && !draining && addr_ok;
    // covers both an out-of-range address and any write attempted while draining
    assign wr_drop = Start && !wr_en;

    always_comb begin
        mask_set = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (WriteReg == ADDR_W'(i))) begin
                mask_set[i] = 1'b1;
            end
        end
    end

    assign mask_nxt  = valid_mask | mask_set;
    assign mask_full = wr_en && (&mask_nxt);
    assign fire      = out_valid && out_ready;

    conv_result_drain_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_drain_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .mask_full  (mask_full),
        .fire       (fire),
        .draining   (draining),
        .rd_ptr     (rd_ptr),
        .drain_done (drain_done)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mask_set[i]) begin
`ifdef CONV_RESULT_ACCUM_EN
                    mem[i] <= valid_mask[i] ? (mem[i] + WriteData) : WriteData;
`else
                    mem[i] <= WriteData;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            valid_mask <= '0;
        end else if (drain_done) begin
            valid_mask <= '0;
        end else begin
            valid_mask <= mask_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            overflow <= 1'b0;
        end else if (wr_drop) begin
            overflow <= 1'b1;
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (draining && (rd_ptr == ADDR_W'(i))) begin
                out_data = mem[i];
            end
        end
    end

    assign out_addr  = draining ? rd_ptr : '0;
    assign out_valid = draining;
    assign full      = draining;

endmodule

// File: tb/tb_conv_result_regfile.sv
`timescale 1ns/1ps
module tb_conv_result_regfile;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 15;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              Start = 1'b0;
    logic [ADDR_W-1:0] WriteReg = '0;
    logic [DATA_W-1:0] WriteData = '0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              full;
    logic              overflow;

    int vectors = 0;
    int miscompares = 0;
    int got [DEPTH];

    conv_result_regfile dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Start     (Start),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .full      (full),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: slot contents, which slots are filled, whether a
    // drain is in progress and which slot is being offered.
    int m_mem [DEPTH];
    bit m_filled [DEPTH];
    bit m_drain;
    int m_idx;
    bit m_ovf;

    always @(posedge clk or posedge rst_n) begin
        int a;
        int cnt;
        if (rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i] = 0;
                m_filled[i] = 0;
            end
            m_drain = 0;
            m_idx = 0;
            m_ovf = 0;
        end else if (!m_drain) begin
            if (Start) begin
                a = int'(WriteReg);
                if (a < DEPTH) begin
`ifdef CONV_RESULT_ACCUM_EN
                    if (m_filled[a]) m_mem[a] = (m_mem[a] + int'(WriteData)) % 65536;
                    else m_mem[a] = int'(WriteData);
`else
                    m_mem[a] = int'(WriteData);
`endif
                    m_filled[a] = 1;
                    cnt = 0;
                    for (int i = 0; i < DEPTH; i++) cnt += int'(m_filled[i]);
                    if (cnt == DEPTH) begin
                        m_drain = 1;
                        m_idx = 0;
                    end
                end else begin
                    m_ovf = 1;
                end
            end
        end else begin
            if (Start) m_ovf = 1;
            if (out_ready) begin
                m_idx++;
                if (m_idx == DEPTH) begin
                    m_drain = 0;
                    m_idx = 0;
                    for (int i = 0; i < DEPTH; i++) m_filled[i] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("out_valid", int'(out_valid), int'(m_drain));
        chk("full", int'(full), int'(m_drain));
        chk("out_data", int'(out_data), m_drain ? m_mem[m_idx] : 0);
        chk("out_addr", int'(out_addr), m_drain ? m_idx : 0);
        chk("overflow", int'(overflow), int'(m_ovf));
    end

    task automatic wr(input int a, input int d);
        @(negedge clk); #1;
        Start = 1'b1;
        WriteReg = ADDR_W'(a);
        WriteData = DATA_W'(d);
    endtask

    task automatic end_writes();
        @(negedge clk); #1;
        Start = 1'b0;
    endtask

    task automatic fill_all(input bit rev, input int base);
        for (int k = 0; k < DEPTH; k++) begin
            if (rev) wr(DEPTH - 1 - k, base + DEPTH - 1 - k);
            else wr(k, base + k);
        end
        end_writes();
    endtask

    task automatic drain_run(input bit rnd_ready);
        int n;
        int budget;
        n = 0;
        budget = 0;
        for (int i = 0; i < DEPTH; i++) got[i] = -1;
        while (n < DEPTH && budget < 400) begin
            out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (out_valid && out_ready) begin
                got[int'(out_addr)] = int'(out_data);
                n++;
            end
            @(negedge clk); #1;
            budget++;
        end
        if (n < DEPTH) chk("drain_timeout", n, DEPTH);
        out_ready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int exp3;

        // reset
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_overflow", int'(overflow), 0);
        rst_n = 1'b0;

        // in-order fill, continuous drain
        out_ready = 1'b1;
        fill_all(0, 'h0100);
        chk("fill_full", int'(full), 1);
        chk("fill_valid", int'(out_valid), 1);
        chk("drain0_data", int'(out_data), 'h0100);
        chk("drain0_addr", int'(out_addr), 0);
        for (int i = 1; i < DEPTH; i++) begin
            @(negedge clk); #1;
            chk("drain_seq_data", int'(out_data), 'h0100 + i);
            chk("drain_seq_addr", int'(out_addr), i);
        end
        @(negedge clk); #1;
        chk("post_drain_full", int'(full), 0);
        chk("post_drain_valid", int'(out_valid), 0);

        // reverse fill with stalled downstream
        out_ready = 1'b0;
        fill_all(1, 'h0100);
        for (int k = 0; k < 5; k++) begin
            chk("stall_data", int'(out_data), 'h0100);
            chk("stall_addr", int'(out_addr), 0);
            @(negedge clk); #1;
        end
        drain_run(0);
        for (int i = 0; i < DEPTH; i++) chk("rev_slot", got[i], 'h0100 + i);

        // rewrite of slot 3
        wr(3, 'h0005);
        wr(3, 'h0007);
        for (int a = 0; a < DEPTH; a++) if (a != 3) wr(a, 'h0200 + a);
        end_writes();
        drain_run(1);
`ifdef CONV_RESULT_ACCUM_EN
        exp3 = 'h000C;
`else
        exp3 = 'h0007;
`endif
        chk("rewrite_slot3", got[3], exp3);
        chk("rewrite_slot0", got[0], 'h0200);

        // overflow: out-of-range address, then a write during drain
        wr(15, 'hDEAD);
        end_writes();
        chk("ovf_addr15", int'(overflow), 1);
        fill_all(0, 'h0300);
        out_ready = 1'b0;
        wr(2, 'hBEEF);
        end_writes();
        chk("ovf_drain_write", int'(overflow), 1);
        drain_run(0);
        chk("ovf_slot2_kept", got[2], 'h0302);
        chk("ovf_sticky", int'(overflow), 1);

        // reset in the middle of a drain
        fill_all(0, 'h0400);
        out_ready = 1'b1;
        b = 0;
        while (out_addr != ADDR_W'(6) && b < 50) begin
            @(negedge clk); #1;
            b++;
        end
        if (b >= 50) chk("wait_idx6_timeout", b, 6);
        rst_n = 1'b1;
        #1;
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_full", int'(full), 0);
        chk("midrst_data", int'(out_data), 0);
        chk("midrst_addr", int'(out_addr), 0);
        chk("midrst_overflow", int'(overflow), 0);
        @(negedge clk); #1;
        rst_n = 1'b0;
        fill_all(0, 'h0500);
        drain_run(0);
        for (int i = 0; i < DEPTH; i++) chk("after_rst_slot", got[i], 'h0500 + i);

        // one slot missing keeps the file in fill
        for (int a = 0; a < DEPTH; a++) if (a != 9) wr(a, 'h0600 + a);
        end_writes();
        for (int k = 0; k < 3; k++) begin
            chk("partial_full", int'(full), 0);
            chk("partial_valid", int'(out_valid), 0);
            @(negedge clk); #1;
        end
        wr(9, 'h0609);
        end_writes();
        chk("slot9_full", int'(full), 1);
        chk("slot9_valid", int'(out_valid), 1);
        drain_run(0);
        chk("slot9_data", got[9], 'h0609);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            rst_n = ($urandom_range(0, 399) == 0);
            Start = ($urandom_range(0, 1) == 1);
            WriteReg = ADDR_W'($urandom_range(0, 15));
            WriteData = DATA_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk); #1;
        Start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
